// File: rtl/xadc_drp_reader.sv
// xadc_drp_reader: issues one DRP read of CHANNEL_ADDR per XADC end-of-sequence and returns the sample with a 1-cycle valid.
// Optional read watchdog enabled by macro XADC_DRP_TIMEOUT_EN.  Rev 1.0
`default_nettype none

module xadc_drp_reader #(
  parameter logic [6:0]  CHANNEL_ADDR   = 7'h1F,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        eos_in,
  input  logic        busy_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic [6:0]  daddr_out,
  output logic        den_out,
  output logic        dwe_out,
  output logic [15:0] di_out,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_EOS  = 2'd1,
    S_ISSUE     = 2'd2,
    S_WAIT_DRDY = 2'd3
  } state_t;

  state_t      state_q;
  logic        eos_q;
  logic        den_q;
  logic        valid_q;
  logic [15:0] data_q;
  logic        eos_rise;
  logic        unused_ok;

  assign eos_rise  = eos_in & ~eos_q;
  // busy_in is informational only; the read handshake alone paces the FSM.
  assign unused_ok = busy_in ^ (TIMEOUT_CYCLES == 0);

`ifdef XADC_DRP_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             terr_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      eos_q   <= 1'b0;
      den_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 16'h0000;
`ifdef XADC_DRP_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      eos_q   <= eos_in;
      den_q   <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_WAIT_EOS;
`ifdef XADC_DRP_TIMEOUT_EN
            terr_q  <= 1'b0;
`endif
          end
        end
        S_WAIT_EOS: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (eos_rise) begin
            state_q <= S_ISSUE;
            den_q   <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT_DRDY;
`ifdef XADC_DRP_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        S_WAIT_DRDY: begin
          // A read in flight always completes, even if enable has dropped.
          if (drdy_in) begin
            data_q  <= do_in;
            valid_q <= 1'b1;
            state_q <= enable ? S_WAIT_EOS : S_IDLE;
          end
`ifdef XADC_DRP_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            terr_q  <= 1'b1;
            state_q <= enable ? S_WAIT_EOS : S_IDLE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign daddr_out  = CHANNEL_ADDR;
  assign den_out    = den_q;
  assign dwe_out    = 1'b0;
  assign di_out     = 16'h0000;
  assign data_out   = data_q;
  assign data_valid = valid_q;
`ifdef XADC_DRP_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xadc_drp_reader.sv
// tb_xadc_drp_reader: scenario tasks plus a randomized transaction-level run for xadc_drp_reader.
`default_nettype none

module tb_xadc_drp_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        eos_in = 1'b0;
  logic        busy_in = 1'b0;
  logic        drdy_in = 1'b0;
  logic [15:0] do_in = 16'h0000;
  logic [6:0]  daddr_out;
  logic        den_out;
  logic        dwe_out;
  logic [15:0] di_out;
  logic [15:0] data_out;
  logic        data_valid;
  logic        timeout_err;

  int n_vec = 0;
  int n_err = 0;
  int den_cnt = 0;
  int val_cnt = 0;

  xadc_drp_reader #(.CHANNEL_ADDR(7'h1F), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .eos_in(eos_in), .busy_in(busy_in),
    .drdy_in(drdy_in), .do_in(do_in), .daddr_out(daddr_out), .den_out(den_out),
    .dwe_out(dwe_out), .di_out(di_out), .data_out(data_out), .data_valid(data_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Transaction monitor: counts DRP enable cycles and valid cycles.
  always @(negedge clk) begin
    if (den_out === 1'b1) den_cnt++;
    if (data_valid === 1'b1) val_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    busy_in = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_vec++; if (daddr_out !== 7'h1F) begin n_err++; $display("FAIL reset_daddr got=%h exp=1f", daddr_out); end
    n_vec++; if (den_out !== 1'b0) begin n_err++; $display("FAIL reset_den got=%b exp=0", den_out); end
    n_vec++; if (dwe_out !== 1'b0 || di_out !== 16'h0) begin n_err++; $display("FAIL reset_write got=%b/%h exp=0/0000", dwe_out, di_out); end
    n_vec++; if (data_out !== 16'h0 || data_valid !== 1'b0) begin n_err++; $display("FAIL reset_data got=%h/%b exp=0000/0", data_out, data_valid); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int d0, v0;
    enable = 1'b1;
    tick();
    d0 = den_cnt; v0 = val_cnt;
    eos_in = 1'b1; tick(); eos_in = 1'b0;
    n_vec++; if (den_out !== 1'b1 || daddr_out !== 7'h1F) begin n_err++; $display("FAIL basic_den got=%b/%h exp=1/1f", den_out, daddr_out); end
    tick();
    n_vec++; if (den_out !== 1'b0) begin n_err++; $display("FAIL basic_den_width got=%b exp=0", den_out); end
    tick(); tick();
    drdy_in = 1'b1; do_in = 16'hA5A0; tick(); drdy_in = 1'b0; do_in = 16'h0;
    n_vec++; if (data_valid !== 1'b1 || data_out !== 16'hA5A0) begin n_err++; $display("FAIL basic_capture got=%b/%h exp=1/a5a0", data_valid, data_out); end
    tick();
    n_vec++; if (data_valid !== 1'b0 || data_out !== 16'hA5A0) begin n_err++; $display("FAIL basic_pulse got=%b/%h exp=0/a5a0", data_valid, data_out); end
    n_vec++; if (den_cnt - d0 != 1 || val_cnt - v0 != 1) begin n_err++; $display("FAIL basic_counts got den=%0d val=%0d exp=1/1", den_cnt - d0, val_cnt - v0); end
  endtask

  task automatic test_disabled();
    int d0, v0;
    enable = 1'b0;
    tick(); tick();
    d0 = den_cnt; v0 = val_cnt;
    for (int i = 0; i < 5; i++) begin
      eos_in = 1'b1; tick(); eos_in = 1'b0; tick(); tick();
    end
    n_vec++; if (den_cnt != d0 || val_cnt != v0) begin n_err++; $display("FAIL disabled_counts got den=%0d val=%0d exp=0/0", den_cnt - d0, val_cnt - v0); end
    n_vec++; if (data_out !== 16'hA5A0) begin n_err++; $display("FAIL disabled_hold got=%h exp=a5a0", data_out); end
  endtask

  task automatic test_drop_eos();
    int d0, v0;
    enable = 1'b1;
    tick();
    d0 = den_cnt; v0 = val_cnt;
    eos_in = 1'b1; tick(); eos_in = 1'b0;
    drdy_in = 1'b1; do_in = 16'hDEAD; tick(); drdy_in = 1'b0;
    n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL issue_drdy_ignored got=%b exp=0", data_valid); end
    eos_in = 1'b1; tick(); eos_in = 1'b0; tick(); tick();
    drdy_in = 1'b1; do_in = 16'h0F0F; tick(); drdy_in = 1'b0;
    n_vec++; if (data_valid !== 1'b1 || data_out !== 16'h0F0F) begin n_err++; $display("FAIL drop_capture got=%b/%h exp=1/0f0f", data_valid, data_out); end
    tick(); tick();
    n_vec++; if (den_cnt - d0 != 1) begin n_err++; $display("FAIL drop_single_den got=%0d exp=1", den_cnt - d0); end
    eos_in = 1'b1; tick(); eos_in = 1'b0;
    n_vec++; if (den_out !== 1'b1) begin n_err++; $display("FAIL drop_next_read got=%b exp=1", den_out); end
    tick();
    drdy_in = 1'b1; do_in = 16'h3C3C; tick(); drdy_in = 1'b0;
    tick();
    n_vec++; if (den_cnt - d0 != 2 || val_cnt - v0 != 2 || data_out !== 16'h3C3C) begin n_err++; $display("FAIL drop_totals got den=%0d val=%0d data=%h exp=2/2/3c3c", den_cnt - d0, val_cnt - v0, data_out); end
  endtask

  task automatic test_enable_fall();
    int d0;
    eos_in = 1'b1; tick(); eos_in = 1'b0; tick(); tick();
    drdy_in = 1'b1; do_in = 16'h7E57; enable = 1'b0; tick(); drdy_in = 1'b0;
    n_vec++; if (data_valid !== 1'b1 || data_out !== 16'h7E57) begin n_err++; $display("FAIL enfall_capture got=%b/%h exp=1/7e57", data_valid, data_out); end
    d0 = den_cnt;
    for (int i = 0; i < 3; i++) begin
      eos_in = 1'b1; tick(); eos_in = 1'b0; tick();
    end
    n_vec++; if (den_cnt != d0) begin n_err++; $display("FAIL enfall_idle got den=%0d exp=0", den_cnt - d0); end
  endtask

  task automatic test_stall();
    int v0;
    enable = 1'b1;
    tick();
    v0 = val_cnt;
    eos_in = 1'b1; tick(); eos_in = 1'b0; tick();
    for (int i = 0; i < 7; i++) tick();
`ifdef XADC_DRP_TIMEOUT_EN
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_early got=%b exp=0", timeout_err); end
    tick();
    n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_set got=%b exp=1", timeout_err); end
    tick(); tick();
    eos_in = 1'b1; tick(); eos_in = 1'b0; tick();
`else
    for (int i = 0; i < 10; i++) tick();
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL stall_no_timeout got=%b exp=0", timeout_err); end
    eos_in = 1'b1; tick(); eos_in = 1'b0;
    n_vec++; if (den_out !== 1'b0) begin n_err++; $display("FAIL stall_no_reissue got=%b exp=0", den_out); end
    tick();
`endif
    n_vec++; if (val_cnt != v0) begin n_err++; $display("FAIL stall_no_valid got=%0d exp=0", val_cnt - v0); end
    drdy_in = 1'b1; do_in = 16'h1230; tick(); drdy_in = 1'b0;
    n_vec++; if (data_valid !== 1'b1 || data_out !== 16'h1230) begin n_err++; $display("FAIL stall_recover got=%b/%h exp=1/1230", data_valid, data_out); end
    tick();
`ifdef XADC_DRP_TIMEOUT_EN
    n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err); end
    enable = 1'b0; tick(); tick();
    enable = 1'b1; tick();
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_clear got=%b exp=0", timeout_err); end
`endif
  endtask

  task automatic test_async_reset();
    int v0, d0;
    eos_in = 1'b1; tick(); eos_in = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_vec++; if (den_out !== 1'b0) begin n_err++; $display("FAIL areset_den_issue got=%b exp=0", den_out); end
    tick(); reset = 1'b1; tick();
    eos_in = 1'b1; tick(); eos_in = 1'b0; tick(); tick();
    #2 reset = 1'b0; enable = 1'b0;
    #1;
    n_vec++; if (den_out !== 1'b0 || data_out !== 16'h0) begin n_err++; $display("FAIL areset_wait got=%b/%h exp=0/0000", den_out, data_out); end
    tick(); reset = 1'b1;
    v0 = val_cnt; d0 = den_cnt;
    drdy_in = 1'b1; do_in = 16'hBEEF; tick(); tick(); drdy_in = 1'b0;
    eos_in = 1'b1; tick(); eos_in = 1'b0; tick(); tick();
    n_vec++; if (val_cnt != v0 || den_cnt != d0 || data_out !== 16'h0) begin n_err++; $display("FAIL areset_late_drdy got val=%0d den=%0d data=%h exp=0/0/0000", val_cnt - v0, den_cnt - d0, data_out); end
  endtask

  task automatic test_random();
    int d0, v0, exp_reads, lat;
    logic [15:0] d;
    logic extra, drop_en;
    enable = 1'b1;
    tick();
    d0 = den_cnt; v0 = val_cnt; exp_reads = 0;
    for (int it = 0; it < 30; it++) begin
      for (int g = 0; g < int'($urandom_range(0, 4)); g++) tick();
      d       = 16'($urandom);
      lat     = int'($urandom_range(1, 6));
      extra   = 1'($urandom_range(0, 1));
      drop_en = ($urandom_range(0, 3) == 0);
      eos_in = 1'b1; tick(); eos_in = 1'b0;
      n_vec++; if (den_out !== 1'b1) begin n_err++; $display("FAIL rand_den it=%0d got=%b exp=1", it, den_out); end
      tick();
      eos_in = extra;
      for (int i = 1; i < lat; i++) begin tick(); eos_in = 1'b0; end
      drdy_in = 1'b1; do_in = d;
      if (drop_en) enable = 1'b0;
      tick();
      drdy_in = 1'b0; eos_in = 1'b0;
      exp_reads++;
      n_vec++; if (data_valid !== 1'b1 || data_out !== d) begin n_err++; $display("FAIL rand_capture it=%0d got=%b/%h exp=1/%h", it, data_valid, data_out, d); end
      tick();
      if (drop_en) begin enable = 1'b1; tick(); end
    end
    n_vec++; if (den_cnt - d0 != exp_reads || val_cnt - v0 != exp_reads) begin n_err++; $display("FAIL rand_totals got den=%0d val=%0d exp=%0d", den_cnt - d0, val_cnt - v0, exp_reads); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_disabled();
    test_drop_eos();
    test_enable_fall();
    test_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
